seq_detect_param: RTL and testbench

Parametrised Mealy sequence detector: watches a stream of DATA_W-bit symbols and flags each occurrence of a programmable SEQ_LEN-symbol pattern. It is the generalised successor of the team's fixed 4-symbol 3-bit detector. It adds a loadable pattern, an input valid qualifier, overlap/non-overlap mode and a saturating match counter. It sits between a symbol source and control logic that consumes `done` as a same-cycle match strobe.

---
 rtl/seq_detect_param.sv | 70 +++++++
 tb/tb_seq_detect_param.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: Mealy detector for a loadable SEQ_LEN-symbol pattern with a saturating match counter.
// Defining SEQDET_TIMEOUT_EN adds an idle timeout that drops partial progress and pulses abort.
module seq_detect_param #(
  parameter int DATA_W = 3,
  parameter int SEQ_LEN = 4,
  parameter int IDX_W = $clog2(SEQ_LEN),
  parameter int CNT_W = 8,
  parameter logic [SEQ_LEN*DATA_W-1:0] PATTERN_INIT = 12'h530,
  parameter int TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         inp,
  input  logic                      in_valid,
  input  logic                      overlap,
  input  logic                      load,
  input  logic [SEQ_LEN*DATA_W-1:0] pattern,
  input  logic                      clr_cnt,
  output logic [IDX_W-1:0]          detect,
  output logic [DATA_W-1:0]         outp,
  output logic                      done,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      abort
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);
  logic [SEQ_LEN*DATA_W-1:0] pat_q;
  logic [IDX_W-1:0] s_d;
  logic hit, first, at_last, tmo;
  assign hit = inp == pat_q[detect*DATA_W +: DATA_W];
  assign first = inp == pat_q[DATA_W-1:0];
  assign at_last = detect == LAST;
`ifdef SEQDET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;
  assign tmo = !load && !in_valid && detect != '0 && idle_q == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idle_q <= '0;
      abort <= 1'b0;
    end else begin
      idle_q <= (in_valid || load || tmo || detect == '0) ? '0 : idle_q + 1'b1;
      abort <= tmo;
    end
`else
  assign tmo = 1'b0;
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) detect <= '0;
    else detect <= s_d;
  // A mismatch or a completed match may itself restart the pattern at symbol 0.
  always_comb
    s_d = (load || tmo) ? '0 :
          !in_valid ? detect :
          (hit && !at_last) ? detect + 1'b1 :
          (hit && !overlap) ? '0 :
          first ? IDX_W'(1) : '0;
  always_comb done = in_valid && !load && at_last && hit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pat_q <= PATTERN_INIT;
      outp <= '0;
      match_cnt <= '0;
    end else begin
      if (load) pat_q <= pattern;
      if (in_valid) outp <= inp;
      match_cnt <= clr_cnt ? CNT_W'(done) :
                   (done && match_cnt != '1) ? match_cnt + 1'b1 : match_cnt;
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed vector table plus hand-written corner sequences for seq_detect_param.
module tb_seq_detect_param;
  localparam logic [11:0] DEF = 12'h530;
  localparam logic [11:0] P1 = 12'h2D1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] inp = '0;
  logic in_valid = 1'b0, overlap = 1'b0, load = 1'b0, clr_cnt = 1'b0;
  logic [11:0] pattern = '0;
  logic [1:0] detect, detect2;
  logic [2:0] outp, outp2;
  logic done, done2, abort, abort2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .overlap(overlap), .load(load),
    .pattern(pattern), .clr_cnt(clr_cnt), .detect(detect), .outp(outp), .done(done),
    .match_cnt(match_cnt), .abort(abort)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .overlap(overlap), .load(load),
    .pattern(pattern), .clr_cnt(clr_cnt), .detect(detect2), .outp(outp2), .done(done2),
    .match_cnt(match_cnt2), .abort(abort2)
  );

  typedef struct {
    logic iv; logic [2:0] inp; logic ov; logic ld; logic [11:0] pat; logic clr;
    logic e_done; logic [1:0] e_det; logic [2:0] e_outp; logic [7:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [2:0] i, logic ov, logic ld, logic [11:0] p, logic clr,
                              logic d, logic [1:0] det, logic [2:0] o, logic [7:0] c);
    vec_t v;
    v.iv = iv; v.inp = i; v.ov = ov; v.ld = ld; v.pat = p; v.clr = clr;
    v.e_done = d; v.e_det = det; v.e_outp = o; v.e_cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic iv, input logic [2:0] i, input logic ov, input logic ld,
                       input logic [11:0] p, input logic clr);
    @(negedge clk);
    in_valid = iv; inp = i; overlap = ov; load = ld; pattern = p; clr_cnt = clr;
  endtask

  task automatic sym(input logic [2:0] i, input logic clr, input logic e_done);
    drive(1'b1, i, 1'b0, 1'b0, DEF, clr);
    #1 chk("seq_done", done, e_done);
    @(posedge clk); #1;
  endtask

  initial begin
    // default pattern, non-overlap: 0,6,4,2
    tbl.push_back(mk(1, 0, 0, 0, DEF, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6, 0, 0, DEF, 0, 0, 2, 6, 0));
    tbl.push_back(mk(1, 4, 0, 0, DEF, 0, 0, 3, 4, 0));
    tbl.push_back(mk(1, 2, 0, 0, DEF, 0, 1, 0, 2, 1));
    // 0,6,0,6,4,2: the mismatching 0 restarts at 1
    tbl.push_back(mk(1, 0, 0, 0, DEF, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 6, 0, 0, DEF, 0, 0, 2, 6, 1));
    tbl.push_back(mk(1, 0, 0, 0, DEF, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 6, 0, 0, DEF, 0, 0, 2, 6, 1));
    tbl.push_back(mk(1, 4, 0, 0, DEF, 0, 0, 3, 4, 1));
    tbl.push_back(mk(1, 2, 0, 0, DEF, 0, 1, 0, 2, 2));
    // 0,6, five idle cycles, 4,2
    tbl.push_back(mk(1, 0, 0, 0, DEF, 0, 0, 1, 0, 2));
    tbl.push_back(mk(1, 6, 0, 0, DEF, 0, 0, 2, 6, 2));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 3, 0, 0, DEF, 0, 0, 2, 6, 2));
    tbl.push_back(mk(1, 4, 0, 0, DEF, 0, 0, 3, 4, 2));
    tbl.push_back(mk(1, 2, 0, 0, DEF, 0, 1, 0, 2, 3));
    // final symbol present but not valid, then valid match together with clr_cnt
    tbl.push_back(mk(1, 0, 0, 0, DEF, 0, 0, 1, 0, 3));
    tbl.push_back(mk(1, 6, 0, 0, DEF, 0, 0, 2, 6, 3));
    tbl.push_back(mk(1, 4, 0, 0, DEF, 0, 0, 3, 4, 3));
    tbl.push_back(mk(0, 2, 0, 0, DEF, 0, 0, 3, 4, 3));
    tbl.push_back(mk(1, 2, 0, 0, DEF, 1, 1, 0, 2, 1));
    // load 1,2,3,1 with clr; then 1,2,3,1,2,3,1 non-overlap
    tbl.push_back(mk(1, 2, 0, 1, P1, 1, 0, 0, 2, 0));
    tbl.push_back(mk(1, 1, 0, 0, P1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 2, 0, 0, P1, 0, 0, 2, 2, 0));
    tbl.push_back(mk(1, 3, 0, 0, P1, 0, 0, 3, 3, 0));
    tbl.push_back(mk(1, 1, 0, 0, P1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 2, 0, 0, P1, 0, 0, 0, 2, 1));
    tbl.push_back(mk(1, 3, 0, 0, P1, 0, 0, 0, 3, 1));
    tbl.push_back(mk(1, 1, 0, 0, P1, 0, 0, 1, 1, 1));
    // reload + clear, then the same stream in overlap mode
    tbl.push_back(mk(0, 0, 1, 1, P1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, P1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 2, 1, 0, P1, 0, 0, 2, 2, 0));
    tbl.push_back(mk(1, 3, 1, 0, P1, 0, 0, 3, 3, 0));
    tbl.push_back(mk(1, 1, 1, 0, P1, 0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 2, 1, 0, P1, 0, 0, 2, 2, 1));
    tbl.push_back(mk(1, 3, 1, 0, P1, 0, 0, 3, 3, 1));
    tbl.push_back(mk(1, 1, 1, 0, P1, 0, 1, 1, 1, 2));
    // load wins over a completing symbol
    tbl.push_back(mk(1, 2, 1, 0, P1, 0, 0, 2, 2, 2));
    tbl.push_back(mk(1, 3, 1, 0, P1, 0, 0, 3, 3, 2));
    tbl.push_back(mk(1, 1, 1, 1, DEF, 0, 0, 0, 1, 2));

    #12;
    chk("rst_detect", detect, 0);
    chk("rst_outp", outp, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_abort", abort, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst = 1'b1;

    foreach (tbl[n]) begin
      drive(tbl[n].iv, tbl[n].inp, tbl[n].ov, tbl[n].ld, tbl[n].pat, tbl[n].clr);
      #1 chk($sformatf("v%0d_done", n), done, tbl[n].e_done);
      @(posedge clk); #1;
      chk($sformatf("v%0d_detect", n), detect, tbl[n].e_det);
      chk($sformatf("v%0d_outp", n), outp, tbl[n].e_outp);
      chk($sformatf("v%0d_cnt", n), match_cnt, tbl[n].e_cnt);
    end

    // saturation on the 2-bit counter instance
    drive(1'b0, 3'd0, 1'b0, 1'b0, DEF, 1'b1);
    @(posedge clk); #1;
    chk("sat_clr", match_cnt2, 0);
    for (int m = 1; m <= 5; m++) begin
      sym(3'd0, 1'b0, 1'b0);
      sym(3'd6, 1'b0, 1'b0);
      sym(3'd4, 1'b0, 1'b0);
      sym(3'd2, 1'b0, 1'b1);
      chk($sformatf("sat_cnt2_m%0d", m), match_cnt2, (m > 3) ? 3 : m);
    end
    chk("sat_cnt8", match_cnt, 5);
    sym(3'd0, 1'b0, 1'b0);
    sym(3'd6, 1'b0, 1'b0);
    sym(3'd4, 1'b0, 1'b0);
    sym(3'd2, 1'b1, 1'b1);
    chk("clr_match_cnt2", match_cnt2, 1);
    chk("clr_match_cnt8", match_cnt, 1);

    // reset asserted at S=3, then the final symbol must not complete a match
    sym(3'd0, 1'b0, 1'b0);
    sym(3'd6, 1'b0, 1'b0);
    sym(3'd4, 1'b0, 1'b0);
    chk("pre_rst_detect", detect, 3);
    drive(1'b0, 3'd2, 1'b0, 1'b0, DEF, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_detect", detect, 0);
    chk("mid_rst_outp", outp, 0);
    chk("mid_rst_cnt", match_cnt, 0);
    @(negedge clk) rst = 1'b1;
    sym(3'd2, 1'b0, 1'b0);
    chk("post_rst_detect", detect, 0);
    chk("post_rst_outp", outp, 2);
    chk("post_rst_cnt", match_cnt, 0);
    chk("end_abort", abort, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
